// File: rtl/mc_controller.sv
// Multi-cycle RV32 control FSM: sequences fetch, decode, memory, ALU,
// branch, jump and upper-immediate steps, and drives the datapath selects.
// Every bus-request state is guarded by a timeout that latches a sticky
// bus error.
// Optional feature: define MC_CONTROLLER_TRAP_EN to park illegal opcodes
// in a TRAP state. Without it, illegal opcodes retire as a NOP.
module mc_controller #(
    parameter int XLEN = 32,
    parameter int TO_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     Instr,
    input  logic [XLEN-1:0] RF_OUT1,
    input  logic [XLEN-1:0] RF_OUT2,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            IRWrite,
    output logic            RegWrite,
    output logic            MemReq,
    output logic            AdrSrc,
    output logic [1:0]      MemWrite,
    output logic [1:0]      ResultSrc,
    output logic [1:0]      ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [2:0]      ImmSrc,
    output logic [3:0]      ALUControl,
    output logic [3:0]      state,
    output logic            bus_err
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_UPPER  = 4'd10,
`ifdef MC_CONTROLLER_TRAP_EN
        S_TRAP   = 4'd14,
`endif
        S_BUSERR = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // The timeout fires on the wait that would bring the counter to all-ones.
    localparam logic [TO_W-1:0] WAIT_LAST = {TO_W{1'b1}} - TO_W'(1);

    state_t          state_q;
    state_t          next_state;
    logic [TO_W-1:0] wait_cnt;
    logic            bus_err_q;
    logic            mem_state;
    logic            branch_taken;

    logic            pc_write_c;
    logic            ir_write_c;
    logic            reg_write_c;
    logic            mem_req_c;
    logic [1:0]      mem_write_c;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_b5;
    logic            unused_instr_bits;

    assign opcode            = Instr[6:0];
    assign funct3            = Instr[14:12];
    assign funct7_b5         = Instr[30];
    assign unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

    // Branch comparator over the full register width, selected by funct3.
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = (RF_OUT1 == RF_OUT2);
            3'b001:  branch_taken = (RF_OUT1 != RF_OUT2);
            3'b100:  branch_taken = ($signed(RF_OUT1) <  $signed(RF_OUT2));
            3'b101:  branch_taken = ($signed(RF_OUT1) >= $signed(RF_OUT2));
            3'b110:  branch_taken = (RF_OUT1 <  RF_OUT2);
            3'b111:  branch_taken = (RF_OUT1 >= RF_OUT2);
            default: branch_taken = 1'b0;
        endcase
    end

    // Next-state logic and per-state datapath controls.
    always_comb begin
        next_state  = state_q;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        mem_req_c   = 1'b0;
        mem_write_c = 2'b00;
        mem_state   = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ImmSrc      = 3'b000;
        ALUControl  = 4'b0000;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                mem_state = 1'b1;
                ALUSrcA   = 2'b00;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    next_state = S_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = S_BUSERR;
                end
            end

            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b010;
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_REG, OP_IMM:    next_state = S_EXEC;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL, OP_JALR:   next_state = S_JUMP;
                    OP_LUI, OP_AUIPC:  next_state = S_UPPER;
`ifdef MC_CONTROLLER_TRAP_EN
                    default:           next_state = S_TRAP;
`else
                    default:           next_state = S_FETCH;
`endif
                endcase
            end

            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                if (opcode == OP_STORE) begin
                    ImmSrc     = 3'b101;
                    next_state = S_MEMWR;
                end else begin
                    ImmSrc     = 3'b000;
                    next_state = S_MEMRD;
                end
            end

            S_MEMRD: begin
                mem_req_c = 1'b1;
                mem_state = 1'b1;
                AdrSrc    = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = S_BUSERR;
                end
            end

            S_MEMWB: begin
                reg_write_c = 1'b1;
                ResultSrc   = 2'b01;
                next_state  = S_FETCH;
            end

            S_MEMWR: begin
                mem_req_c = 1'b1;
                mem_state = 1'b1;
                AdrSrc    = 1'b1;
                case (funct3)
                    3'b000:  mem_write_c = 2'b01;
                    3'b001:  mem_write_c = 2'b10;
                    3'b010:  mem_write_c = 2'b11;
                    default: mem_write_c = 2'b00;
                endcase
                if (mem_ready) begin
                    next_state = S_FETCH;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = S_BUSERR;
                end
            end

            S_EXEC: begin
                ALUSrcA = 2'b10;
                if (opcode == OP_REG) begin
                    ALUSrcB    = 2'b00;
                    ALUControl = {funct3, funct7_b5};
                end else begin
                    ALUSrcB = 2'b01;
                    ImmSrc  = (funct3 == 3'b011) ? 3'b001 : 3'b000;
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        ALUControl = {funct3, funct7_b5};
                    end else begin
                        ALUControl = {funct3, 1'b0};
                    end
                end
                next_state = S_ALUWB;
            end

            S_ALUWB: begin
                reg_write_c = 1'b1;
                ResultSrc   = 2'b00;
                next_state  = S_FETCH;
            end

            S_BRANCH: begin
                ResultSrc  = 2'b00;
                pc_write_c = branch_taken;
                next_state = S_FETCH;
            end

            S_JUMP: begin
                // The ALU forms the link value OldPC + 4; the datapath's
                // target adder uses ImmSrc and clears bit 0 for JALR.
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                ImmSrc      = (opcode == OP_JAL) ? 3'b011 : 3'b000;
                next_state  = S_FETCH;
            end

            S_UPPER: begin
                reg_write_c = 1'b1;
                ImmSrc      = 3'b100;
                ALUSrcB     = 2'b01;
                ResultSrc   = 2'b10;
                ALUSrcA     = (opcode == OP_AUIPC) ? 2'b01 : 2'b00;
                next_state  = S_FETCH;
            end

`ifdef MC_CONTROLLER_TRAP_EN
            S_TRAP: begin
                next_state = S_TRAP;
            end
`endif

            S_BUSERR: begin
                next_state = S_BUSERR;
            end

            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // State register, per-state wait counter and sticky bus-error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= next_state;
            if (next_state != state_q) begin
                wait_cnt <= '0;
            end else if (mem_state && !mem_ready) begin
                wait_cnt <= wait_cnt + TO_W'(1);
            end
            if (next_state == S_BUSERR) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // Strobes are forced low while reset is held, even though the state is FETCH.
    assign PCWrite  = pc_write_c  & reset;
    assign IRWrite  = ir_write_c  & reset;
    assign RegWrite = reg_write_c & reset;
    assign MemReq   = mem_req_c   & reset;
    assign MemWrite = mem_write_c & {2{reset}};
    assign state    = state_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller (TO_W = 4 to keep timeouts short).
module tb_mc_controller;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [31:0] RF_OUT1;
    logic [31:0] RF_OUT2;
    logic        mem_ready;
    logic        PCWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemReq;
    logic        AdrSrc;
    logic [1:0]  MemWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic [3:0]  state;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_BLT  = 32'h0020C063;
    localparam logic [31:0] I_BLTU = 32'h0020E063;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

`ifdef MC_CONTROLLER_TRAP_EN
    localparam logic [3:0] ILL_STATE = 4'd14;
`else
    localparam logic [3:0] ILL_STATE = 4'd0;
`endif

    mc_controller #(.XLEN(32), .TO_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .RF_OUT1    (RF_OUT1),
        .RF_OUT2    (RF_OUT2),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemReq     (MemReq),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .state      (state),
        .bus_err    (bus_err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Directed sequence.
    initial begin
        reset     = 1'b0;
        mem_ready = 1'b0;
        Instr     = I_ADD;
        RF_OUT1   = 32'd0;
        RF_OUT2   = 32'd0;

        #12;
        check_output("rst_state",   state,    4'd0);
        check_output("rst_memreq",  MemReq,   1'b0);
        check_output("rst_irwrite", IRWrite,  1'b0);
        check_output("rst_buserr",  bus_err,  1'b0);

        reset = 1'b1;
        #1;
        check_output("rel_state",  state,  4'd0);
        check_output("rel_memreq", MemReq, 1'b1);

        $display("[TB] ADD x3,x1,x2");
        mem_ready = 1'b1;
        #1;
        check_output("fetch_irwrite", IRWrite,  1'b1);
        check_output("fetch_pcwrite", PCWrite,  1'b1);
        check_output("fetch_srcb",    ALUSrcB,  2'b10);
        tick();
        check_output("add_decode",    state,    4'd1);
        check_output("add_dec_rw",    RegWrite, 1'b0);
        tick();
        check_output("add_exec",      state,      4'd6);
        check_output("add_exec_rw",   RegWrite,   1'b0);
        check_output("add_aluctl",    ALUControl, 4'b0000);
        check_output("add_srca",      ALUSrcA,    2'b10);
        check_output("add_srcb",      ALUSrcB,    2'b00);
        tick();
        check_output("add_aluwb",     state,     4'd7);
        check_output("add_wb_rw",     RegWrite,  1'b1);
        check_output("add_wb_res",    ResultSrc, 2'b00);
        tick();
        check_output("add_back",      state,     4'd0);
        check_output("add_back_rw",   RegWrite,  1'b0);

        $display("[TB] SW with three wait cycles");
        Instr = I_SW;
        tick();
        check_output("sw_decode", state, 4'd1);
        tick();
        check_output("sw_memadr", state,  4'd2);
        check_output("sw_imm",    ImmSrc, 3'b101);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            check_output("sw_state",  state,    4'd5);
            check_output("sw_memreq", MemReq,   1'b1);
            check_output("sw_size",   MemWrite, 2'b11);
            check_output("sw_adrsrc", AdrSrc,   1'b1);
            tick();
        end
        check_output("sw_back",   state,    4'd0);
        check_output("sw_nowr",   MemWrite, 2'b00);

        $display("[TB] LW");
        Instr = I_LW;
        tick();
        tick();
        check_output("lw_memadr", state,  4'd2);
        check_output("lw_imm",    ImmSrc, 3'b000);
        tick();
        check_output("lw_memrd",  state,    4'd3);
        check_output("lw_nowr",   MemWrite, 2'b00);
        tick();
        check_output("lw_memwb",  state,     4'd4);
        check_output("lw_wb_rw",  RegWrite,  1'b1);
        check_output("lw_wb_res", ResultSrc, 2'b01);
        tick();
        check_output("lw_back",   state, 4'd0);

        $display("[TB] BLT / BLTU with -1 vs 1");
        RF_OUT1 = 32'hFFFF_FFFF;
        RF_OUT2 = 32'h0000_0001;
        Instr   = I_BLT;
        tick();
        tick();
        check_output("blt_state", state,   4'd8);
        check_output("blt_taken", PCWrite, 1'b1);
        tick();
        check_output("blt_back",  state,   4'd0);
        Instr = I_BLTU;
        tick();
        tick();
        check_output("bltu_state", state,   4'd8);
        check_output("bltu_taken", PCWrite, 1'b0);
        tick();

        $display("[TB] illegal opcode 0x7F");
        Instr = I_ILL;
        tick();
        check_output("ill_decode", state, 4'd1);
        tick();
        check_output("ill_next", state, ILL_STATE);
        tick();
        tick();
        if (ILL_STATE == 4'd14) begin
            check_output("ill_stuck",  state,  4'd14);
            check_output("ill_memreq", MemReq, 1'b0);
        end

        // Return to a clean FETCH regardless of the build.
        reset = 1'b0;
        #3;
        reset = 1'b1;
        #1;

        $display("[TB] reset during MEMRD");
        Instr     = I_LW;
        mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        check_output("rd_state",  state,  4'd3);
        check_output("rd_memreq", MemReq, 1'b1);
        reset = 1'b0;
        #1;
        check_output("rd_rst_state",  state,  4'd0);
        check_output("rd_rst_memreq", MemReq, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check_output("rd_rel_state",  state,  4'd0);
        check_output("rd_rel_memreq", MemReq, 1'b1);
        check_output("rd_rel_adr",    AdrSrc, 1'b0);

        $display("[TB] fetch timeout");
        reset = 1'b0;
        #1;
        reset = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        check_output("to_wait_state", state,   4'd0);
        check_output("to_wait_err",   bus_err, 1'b0);
        tick();
        check_output("to_state",  state,   4'd15);
        check_output("to_err",    bus_err, 1'b1);
        check_output("to_memreq", MemReq,  1'b0);
        mem_ready = 1'b1;
        tick();
        tick();
        check_output("to_held_state", state,   4'd15);
        check_output("to_held_err",   bus_err, 1'b1);
        check_output("to_held_pcw",   PCWrite, 1'b0);
        reset = 1'b0;
        #1;
        check_output("to_rst_err", bus_err, 1'b0);
        mem_ready = 1'b0;
        reset     = 1'b1;
        #1;
        check_output("to_rel_state", state, 4'd0);

        $display("[TB] mem_ready on the last wait cycle");
        for (int i = 0; i < 14; i++) tick();
        check_output("late_wait_state", state, 4'd0);
        mem_ready = 1'b1;
        tick();
        check_output("late_state", state,   4'd1);
        check_output("late_err",   bus_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter XLEN, default 32, width of the register-file operands fed to the branch comparator.
REQ-002 Parameter TO_W, default 8, width of the memory-wait timeout counter.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Instr  input  32  instruction-register contents.
REQ-006 RF_OUT1, RF_OUT2  input  XLEN each  rs1/rs2 register-file read data.
REQ-007 mem_ready  input  1  memory/UART bus accepted or completed the current access.
REQ-008 PCWrite, IRWrite, RegWrite, MemReq, AdrSrc  output  1 each  PC load, IR load, RF write, bus request, bus address select (0 = PC, 1 = ALUOut).
REQ-009 MemWrite  output  2  store size: 00 = none, 01 = byte, 10 = half, 11 = word.
REQ-010 ResultSrc  output  2  00 = ALUOut, 01 = read data, 10 = ALU result.
REQ-011 ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = rs1.
REQ-012 ALUSrcB  output  2  00 = rs2, 01 = immediate, 10 = constant 4.
REQ-013 ImmSrc  output  3  000 = SEX12, 001 = UEX12 (SLTIU), 010 = B, 011 = J, 100 = U, 101 = S.
REQ-014 ALUControl  output  4  {funct3, funct7[5]} for R-type and shift-immediate ops; {funct3, 0} for other I-type ops; 0000 (add) otherwise.
REQ-015 state  output  4  current FSM state; bus_err  output  1  sticky bus-timeout flag.

Function
REQ-016 State encoding SHALL be: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, JUMP = 9, UPPER = 10, TRAP = 14, BUSERR = 15.
REQ-017 FETCH: MemReq = 1, AdrSrc = 0; on mem_ready = 1, IRWrite = PCWrite = 1 (PC <- PC + 4, via ALUSrcA = 00, ALUSrcB = 10) and the FSM goes to DECODE; otherwise it stays in FETCH.
REQ-018 DECODE: computes OldPC + B-immediate into ALUOut; next state by opcode: load/store -> MEMADR, R/I-ALU -> EXEC, branch -> BRANCH, JAL/JALR -> JUMP, LUI/AUIPC -> UPPER, anything else -> TRAP.
REQ-019 MEMADR: computes rs1 + imm (ImmSrc 000 for loads, 101 for stores), then goes to MEMRD for loads or MEMWR for stores.
REQ-020 MEMRD: MemReq = 1, AdrSrc = 1; goes to MEMWB on mem_ready. MEMWB: RegWrite = 1, ResultSrc = 01, then FETCH.
REQ-021 MEMWR: MemReq = 1, AdrSrc = 1, MemWrite = size from funct3 (SB = 01, SH = 10, SW = 11, other = 00); goes to FETCH on mem_ready.
REQ-022 EXEC: ALUSrcA = 10, ALUSrcB = 00 (R-type) or 01 (I-type); then ALUWB, which asserts RegWrite = 1, ResultSrc = 00, then FETCH.
REQ-023 BRANCH: comparator EQ/NE/LT/GE (signed)/LTU/GEU on RF_OUT1/RF_OUT2 by funct3; taken -> PCWrite = 1, result = ALUOut; undefined funct3 -> not taken; then FETCH.
REQ-024 JUMP: RegWrite = 1 (rd <- OldPC + 4); PCWrite = 1 with target OldPC + J-imm (JAL) or (rs1 + imm) & ~1 (JALR); then FETCH.
REQ-025 UPPER: RegWrite = 1, ImmSrc = 100; LUI uses ALUSrcA = 00 with zeroed operand, AUIPC uses ALUSrcA = 01; then FETCH.
REQ-026 Every MemReq state SHALL hold MemReq and address stable until mem_ready; a wait counter (TO_W bits) SHALL clear on state entry and increment per unready cycle.
REQ-027 If the wait counter reaches 2^TO_W - 1 without mem_ready, the FSM SHALL enter BUSERR, set bus_err = 1, and hold all strobes at 0 until reset; mem_ready arriving on that same cycle SHALL win (normal advance).
REQ-028 The comparator SHALL be XLEN bits wide, and XLEN SHALL not affect the instruction-field decode.

Reset
REQ-029 While reset = 0, the FSM SHALL be in FETCH, the wait counter and bus_err SHALL be 0, and all write/request strobes SHALL be 0.
REQ-030 Reset asserted mid-access SHALL abort it immediately; the first cycle after release SHALL be FETCH with MemReq = 1.

Configuration
REQ-031 Macro MC_CONTROLLER_TRAP_EN defined: illegal opcode -> TRAP, all strobes held at 0, state = 14 until reset.
REQ-032 Macro undefined: TRAP does not exist, illegal opcode -> FETCH (treated as NOP, PC already advanced).

Verification
REQ-033 ADD x3,x1,x2 (0x002081B3) with mem_ready always 1 -> states 0,1,6,7,0; RegWrite only in state 7; ALUControl = 0000.
REQ-034 SW with mem_ready held low 3 cycles in MEMWR -> MemReq and MemWrite = 11 stable for 4 cycles, then FETCH.
REQ-035 BLT with RF_OUT1 = 0xFFFFFFFF, RF_OUT2 = 1 -> PCWrite = 1 in BRANCH; same operands with BLTU -> PCWrite = 0.
REQ-036 TO_W = 4, mem_ready stuck 0 in FETCH -> BUSERR after 15 waiting cycles, bus_err = 1, cleared only by reset.
REQ-037 Opcode 0x7F with the macro defined -> state = 14 and stuck; with the macro undefined -> returns to FETCH.
REQ-038 reset pulsed low during MEMRD -> outputs clear asynchronously; the first cycle after release is state 0 with MemReq = 1.
